decode_stage: RTL and testbench

Decode stage between `fetch` and rename/dispatch. Accepts one RV32I instruction per cycle from fetch over a valid/ready handshake and extracts register indices, a sign-extended immediate, a functional-unit class and control flags. Results are presented through a two-entry skid buffer, so every output, including the ready signal back to fetch, is registered.

---
 rtl/decode_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between fetch and rename/dispatch.
// Each instruction word is decoded combinationally, then captured in a
// two-entry skid buffer (OUT, SKID). Every output is driven from a register,
// including ready_out, so nothing in this block is a combinational path from
// ready_in back to fetch.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_4_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic            flush,
    input  logic            ready_in,
    output logic            valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_4_out,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [31:0]     imm,
    output logic [1:0]      fu_type,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            writes_rd,
    output logic            illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] FU_ALU = 2'b00;
    localparam logic [1:0] FU_BR  = 2'b01;
    localparam logic [1:0] FU_LSU = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [31:0]     imm;
        logic [1:0]      fu_type;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Immediate candidates for every format; the opcode picks one.
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    assign imm_i_s = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b_s = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                      instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u_s = {instr_in[31:12], 12'b0};
    assign imm_j_s = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                      instr_in[20], instr_in[30:21], 1'b0};

    bundle_t dec_s;
    logic    wr_raw_s;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        dec_s          = '0;
        wr_raw_s       = 1'b0;
        dec_s.pc       = pc_in;
        dec_s.pc_4     = pc_4_in;
        dec_s.rs1      = instr_in[19:15];
        dec_s.rs2      = instr_in[24:20];
        dec_s.rd       = instr_in[11:7];
        dec_s.opcode   = instr_in[6:0];
        dec_s.funct3   = instr_in[14:12];
        dec_s.funct7   = instr_in[31:25];
        case (instr_in[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_s.imm = imm_u_s; dec_s.fu_type = FU_ALU; wr_raw_s = 1'b1;
            end
            OPC_JAL: begin
                dec_s.imm = imm_j_s; dec_s.fu_type = FU_BR; wr_raw_s = 1'b1;
            end
            OPC_JALR: begin
                dec_s.imm = imm_i_s; dec_s.fu_type = FU_BR;
                dec_s.uses_rs1 = 1'b1; wr_raw_s = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.imm = imm_b_s; dec_s.fu_type = FU_BR;
                dec_s.uses_rs1 = 1'b1; dec_s.uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec_s.imm = imm_i_s; dec_s.fu_type = FU_LSU;
                dec_s.uses_rs1 = 1'b1; wr_raw_s = 1'b1;
            end
            OPC_STORE: begin
                dec_s.imm = imm_s_s; dec_s.fu_type = FU_LSU;
                dec_s.uses_rs1 = 1'b1; dec_s.uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                dec_s.imm = imm_i_s; dec_s.fu_type = FU_ALU;
                dec_s.uses_rs1 = 1'b1; wr_raw_s = 1'b1;
            end
            OPC_OP: begin
                dec_s.imm = 32'd0; dec_s.fu_type = FU_ALU;
                dec_s.uses_rs1 = 1'b1; dec_s.uses_rs2 = 1'b1; wr_raw_s = 1'b1;
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        // Writing x0 has no architectural effect, so dispatch never sees it.
        dec_s.writes_rd = wr_raw_s && (instr_in[11:7] != 5'd0);
    end

    state_t  state_q, state_d;
    bundle_t out_q, out_d, skid_q, skid_d;
    logic    valid_q, valid_d, ready_q, ready_d;
    logic    accept_s, emit_s;

    assign accept_s = valid_in && ready_q;
    assign emit_s   = valid_q && ready_in;

    // Skid-buffer next state: which register loads, and where the FSM goes.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        out_d   = dec_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (emit_s && accept_s) begin
                        out_d = dec_s;
                    end else if (emit_s) begin
                        state_d = ST_EMPTY;
                    end else if (accept_s) begin
                        skid_d  = dec_s;
                        state_d = ST_TWO;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (emit_s) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake flags are registered copies of the next-state occupancy.
    assign valid_d = (state_d != ST_EMPTY);
    assign ready_d = (state_d != ST_TWO);

    // State and data registers; reset empties both entries at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_out = ready_q;
    assign valid_out = valid_q;
    assign pc_out    = out_q.pc;
    assign pc_4_out  = out_q.pc_4;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd        = out_q.rd;
    assign opcode    = out_q.opcode;
    assign funct3    = out_q.funct3;
    assign funct7    = out_q.funct7;
    assign imm       = out_q.imm;
    assign fu_type   = out_q.fu_type;
    assign uses_rs1  = out_q.uses_rs1;
    assign uses_rs2  = out_q.uses_rs2;
    assign writes_rd = out_q.writes_rd;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-decoded expected
// bundles on accept, a negedge monitor pops and compares on every emit.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, valid_in, flush, ready_in;
    logic [31:0] instr_in, pc_in, pc_4_in;
    logic        ready_out, valid_out;
    logic [31:0] pc_out, pc_4_out, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [1:0]  fu_type;
    logic        uses_rs1, uses_rs2, writes_rd, illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .pc_4_in(pc_4_in), .valid_in(valid_in), .ready_out(ready_out),
        .flush(flush), .ready_in(ready_in), .valid_out(valid_out),
        .pc_out(pc_out), .pc_4_out(pc_4_out), .rs1(rs1), .rs2(rs2), .rd(rd),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm),
        .fu_type(fu_type), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .writes_rd(writes_rd), .illegal(illegal)
    );

    // Full observed bundle: pc, pc_4, then the 70-bit decoded part.
    logic [133:0] act;
    assign act = {pc_out, pc_4_out, rs1, rs2, rd, opcode, funct3, funct7, imm,
                  fu_type, uses_rs1, uses_rs2, writes_rd, illegal};

    logic [31:0]  instr_tab [9];
    logic [69:0]  dec_tab   [9];
    logic [133:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;

    function automatic logic [69:0] mk(input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] d, input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] im, input logic [1:0] fu,
        input logic u1, input logic u2, input logic wr, input logic il);
        return {r1, r2, d, op, f3, f7, im, fu, u1, u2, wr, il};
    endfunction

    task automatic chk(input string name, input logic [133:0] got, input logic [133:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Present table entry idx until accepted; returns #1 after the accept edge.
    task automatic send(input int idx, input logic [31:0] pc);
        logic done;
        done     = 1'b0;
        instr_in = instr_tab[idx];
        pc_in    = pc;
        pc_4_in  = pc + 32'd4;
        valid_in = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ready_out) begin
                exp_q.push_back({pc, pc + 32'd4, dec_tab[idx]});
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout got=not_accepted want=accepted idx=%0d", idx);
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every emit must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && valid_out && ready_in) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got pc=%h want=no_output", pc_out);
            end else begin
                logic [133:0] e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL decode got=%h want=%h", act, e);
                end
            end
        end
    end

    initial begin
        //                     rs1    rs2    rd     opcode  f3    f7     imm            fu    u1 u2 wr il
        instr_tab[0] = 32'h00500093; dec_tab[0] = mk(5'd0, 5'd5, 5'd1,  7'h13, 3'd0, 7'h00, 32'h00000005, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        instr_tab[1] = 32'h0020A423; dec_tab[1] = mk(5'd1, 5'd2, 5'd8,  7'h23, 3'd2, 7'h00, 32'h00000008, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        instr_tab[2] = 32'hFE208EE3; dec_tab[2] = mk(5'd1, 5'd2, 5'd29, 7'h63, 3'd0, 7'h7F, 32'hFFFFFFFC, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        instr_tab[3] = 32'h123452B7; dec_tab[3] = mk(5'd8, 5'd3, 5'd5,  7'h37, 3'd5, 7'h09, 32'h12345000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        instr_tab[4] = 32'h0000007F; dec_tab[4] = mk(5'd0, 5'd0, 5'd0,  7'h7F, 3'd0, 7'h00, 32'h00000000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        instr_tab[5] = 32'h00000013; dec_tab[5] = mk(5'd0, 5'd0, 5'd0,  7'h13, 3'd0, 7'h00, 32'h00000000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        instr_tab[6] = 32'h008000EF; dec_tab[6] = mk(5'd0, 5'd8, 5'd1,  7'h6F, 3'd0, 7'h00, 32'h00000008, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        instr_tab[7] = 32'hFFF12183; dec_tab[7] = mk(5'd2, 5'd31, 5'd3, 7'h03, 3'd2, 7'h7F, 32'hFFFFFFFF, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        instr_tab[8] = 32'h002081B3; dec_tab[8] = mk(5'd1, 5'd2, 5'd3,  7'h33, 3'd0, 7'h00, 32'h00000000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        reset = 1'b0; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b0;
        instr_in = 32'd0; pc_in = 32'd0; pc_4_in = 32'd0;
        #12;
        chk("reset_data", act, 134'd0);
        chk1("reset_valid", valid_out, 1'b0);
        chk1("reset_ready", ready_out, 1'b1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Single instruction then back-to-back stream at full rate.
        ready_in = 1'b1;
        stalls = 0;
        send(0, 32'h100);
        chk1("latency_valid", valid_out, 1'b1);
        send(1, 32'h104); send(2, 32'h108); send(3, 32'h10C); send(6, 32'h110);
        send(7, 32'h114); send(8, 32'h118); send(4, 32'h11C); send(5, 32'h120);
        chk("throughput_stalls", 134'(stalls), 134'd0);
        idle(3);

        // Backpressure: A, B fill OUT and SKID; C is held by fetch.
        ready_in = 1'b0;
        send(1, 32'h200);
        send(2, 32'h204);
        chk1("bp_ready_low", ready_out, 1'b0);
        chk("bp_hold_A", act, {32'h200, 32'h204, dec_tab[1]});
        instr_in = instr_tab[3]; pc_in = 32'h208; pc_4_in = 32'h20C; valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("bp_ready_still_low", ready_out, 1'b0);
        chk("bp_hold_A_later", act, {32'h200, 32'h204, dec_tab[1]});
        ready_in = 1'b1;
        send(3, 32'h208);
        idle(4);

        // Flush in state TWO with a valid input in the same cycle.
        ready_in = 1'b0;
        send(5, 32'h300);
        send(8, 32'h304);
        instr_in = instr_tab[6]; pc_in = 32'h308; pc_4_in = 32'h30C;
        valid_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        exp_q.delete();
        chk1("flush_valid", valid_out, 1'b0);
        chk1("flush_ready", ready_out, 1'b1);
        ready_in = 1'b1;
        idle(5);

        // Asynchronous reset between edges while in state ONE.
        ready_in = 1'b0;
        send(0, 32'h400);
        valid_in = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk1("async_reset_valid", valid_out, 1'b0);
        chk1("async_reset_ready", ready_out, 1'b1);
        exp_q.delete();
        #3;
        reset = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b1;
        stalls = 0;
        send(7, 32'h500);
        chk("post_reset_stalls", 134'(stalls), 134'd0);
        idle(1);

        // Drain: every expected instruction must have come out.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_left", 134'(exp_q.size()), 134'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
